// File: rtl/iformat_pkg.sv
// Shared opcode, state and instruction-field definitions for the I-format
// execute/write-back sequencer.
package iformat_pkg;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/iformat_alu.sv
// Combinational I-format ALU: applies the 16-bit immediate to the rs value
// and flags illegal opcodes and addi signed overflow.
module iformat_alu
    import iformat_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] value,
    output logic              illegal,
    output logic              ovf
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] sext_s;
    logic signed [DATA_W-1:0] sum_s;
    logic        [DATA_W-1:0] zext;
    logic                     sum_ovf;

    always_comb begin
        a_s     = signed'(rs_val);
        sext_s  = signed'({{(DATA_W-16){imm[15]}}, imm});
        zext    = {{(DATA_W-16){1'b0}}, imm};
        sum_s   = a_s + sext_s;
        // Overflow only when both operands share a sign the sum does not.
        sum_ovf = (a_s[DATA_W-1] == sext_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_s[DATA_W-1]);

        value   = '0;
        illegal = 1'b0;
        ovf     = 1'b0;
        case (opcode)
            OP_ADDI: begin
                value = unsigned'(sum_s);
                ovf   = sum_ovf;
            end
            OP_ADDIU: value = unsigned'(sum_s);
            OP_SLTI:  value = {{(DATA_W-1){1'b0}}, (a_s < sext_s)};
            OP_SLTIU: value = {{(DATA_W-1){1'b0}}, (rs_val < unsigned'(sext_s))};
            OP_ANDI:  value = rs_val & zext;
            OP_ORI:   value = rs_val | zext;
            OP_XORI:  value = rs_val ^ zext;
            OP_LUI:   value = {{(DATA_W-16){1'b0}}, imm} << 16;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/iformat_exec.sv
// Four-cycle I-format sequencer: IDLE accepts, READ fetches rs, EXEC computes,
// WRITE drives the register file; done/flags are reported after WRITE.
module iformat_exec
    import iformat_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              wrote,
    output logic              err,
    output logic              ovf
);

    state_t              state_q;
    logic [5:0]          opc_q;
    logic [4:0]          rt_q;
    logic [15:0]         imm_q;
    logic                ready_q, rf_we_q, done_q, wrote_q, err_q, ovf_q;
    logic                ex_err_q, ex_ovf_q;
    logic [REG_AW-1:0]   rf_addr_q;
    logic [DATA_W-1:0]   rf_wdata_q, result_q;

    logic [DATA_W-1:0]   alu_val_d;
    logic                alu_ill_d, alu_ovf_d, wr_ok_d;

    iformat_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode  (opc_q),
        .rs_val  (rf_rdata),
        .imm     (imm_q),
        .value   (alu_val_d),
        .illegal (alu_ill_d),
        .ovf     (alu_ovf_d)
    );

    assign wr_ok_d = !alu_ill_d && !alu_ovf_d && (rt_q != 5'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            wrote_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ex_err_q   <= 1'b0;
            ex_ovf_q   <= 1'b0;
        end else begin
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (instr_valid && ready_q) begin
                        opc_q     <= instr[OPC_HI:OPC_LO];
                        rt_q      <= instr[RT_HI:RT_LO];
                        imm_q     <= instr[IMM_HI:IMM_LO];
                        // rs goes straight out so the read data lands in EXEC.
                        rf_addr_q <= REG_AW'(instr[RS_HI:RS_LO]);
                        ready_q   <= 1'b0;
                        state_q   <= S_READ;
                    end
                end
                S_READ: state_q <= S_EXEC;
                S_EXEC: begin
                    rf_addr_q  <= REG_AW'(rt_q);
                    rf_wdata_q <= alu_val_d;
                    rf_we_q    <= wr_ok_d;
                    ex_err_q   <= alu_ill_d;
                    ex_ovf_q   <= alu_ovf_d;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b1;
                    result_q <= rf_wdata_q;
                    wrote_q  <= rf_we_q;
                    err_q    <= ex_err_q;
                    ovf_q    <= ex_ovf_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign rf_addr     = rf_addr_q;
    assign rf_we       = rf_we_q;
    assign rf_wdata    = rf_wdata_q;
    assign done        = done_q;
    assign result      = result_q;
    assign wrote       = wrote_q;
    assign err         = err_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_iformat_exec.sv
// Bench for iformat_exec: register-file memory, timeline reference model,
// directed cases from the plan and a randomized back-to-back phase.
module tb_iformat_exec;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        done;
    logic [31:0] result;
    logic        wrote;
    logic        err;
    logic        ovf;

    iformat_exec #(.DATA_W(32), .REG_AW(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .done        (done),
        .result      (result),
        .wrote       (wrote),
        .err         (err),
        .ovf         (ovf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        poke_en   = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    // Register file: synchronous write, registered read.
    logic [31:0] rf_mem [32] = '{default: 32'h0};
    always @(posedge clock) begin
        if (poke_en) rf_mem[poke_addr] <= poke_data;
        else if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        rf_rdata <= rf_mem[rf_addr];
    end

    // Architectural result of one instruction, from the opcode table.
    function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                     output logic [31:0] res, output logic we,
                                     output logic e, output logic o);
        logic [31:0] se, ze;
        longint      sa, ss, sum;
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        sa  = longint'($signed(a));
        ss  = longint'($signed(se));
        sum = sa + ss;
        e = 1'b0;
        o = 1'b0;
        case (ins[31:26])
            6'd8:  begin res = a + se; o = (sum > 64'sd2147483647) || (sum < -64'sd2147483648); end
            6'd9:  res = a + se;
            6'd10: res = (sa < ss) ? 32'd1 : 32'd0;
            6'd11: res = (a < se) ? 32'd1 : 32'd0;
            6'd12: res = a & ze;
            6'd13: res = a | ze;
            6'd14: res = a ^ ze;
            6'd15: res = ins[15:0] * 32'd65536;
            default: begin res = 32'h0; e = 1'b1; end
        endcase
        we = !e && !o && (ins[20:16] != 5'd0);
    endfunction

    // Timeline model: phase counts cycles since accept (1=read, 2=exec, 3=write).
    logic [31:0] golden [32] = '{default: 32'h0};
    bit          started = 1'b0;
    int          m_phase = 0;
    logic        m_ready = 1'b0, m_done = 1'b0;
    logic [4:0]  m_rs = '0, m_rt = '0;
    logic [31:0] m_res = '0, m_result = '0;
    logic        m_we = 1'b0, m_e = 1'b0, m_o = 1'b0;
    logic        m_wrote = 1'b0, m_err = 1'b0, m_ovf = 1'b0;

    always @(posedge clock) begin
        if (poke_en) golden[poke_addr] = poke_data;
        if (m_phase == 3 && m_we) golden[m_rt] = m_res;
        m_done = 1'b0;
        if (!reset) begin
            started  = 1'b1;
            m_phase  = 0;
            m_ready  = 1'b0;
            m_result = '0;
            m_wrote  = 1'b0;
            m_err    = 1'b0;
            m_ovf    = 1'b0;
        end else if (m_phase == 0) begin
            if (m_ready && instr_valid) begin
                m_rs = instr[25:21];
                m_rt = instr[20:16];
                ref_exec(instr, golden[instr[25:21]], m_res, m_we, m_e, m_o);
                m_phase = 1;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else if (m_phase < 3) begin
            m_phase = m_phase + 1;
        end else begin
            m_phase  = 0;
            m_ready  = 1'b1;
            m_done   = 1'b1;
            m_result = m_res;
            m_wrote  = m_we;
            m_err    = m_e;
            m_ovf    = m_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        logic [31:0] e_addr, e_wd;
        logic        e_we;
        @(negedge clock);
        cyc++;
        if (started) begin
            e_addr = (m_phase == 1) ? 32'(m_rs) : (m_phase == 3) ? 32'(m_rt) : 32'h0;
            e_wd   = (m_phase == 3) ? m_res : 32'h0;
            e_we   = (m_phase == 3) && m_we;
            chk("instr_ready", 32'(instr_ready), 32'(m_ready));
            chk("done",        32'(done),        32'(m_done));
            chk("rf_we",       32'(rf_we),       32'(e_we));
            chk("rf_addr",     32'(rf_addr),     e_addr);
            chk("rf_wdata",    rf_wdata,         e_wd);
            chk("result",      result,           m_result);
            chk("wrote",       32'(wrote),       32'(m_wrote));
            chk("err",         32'(err),         32'(m_err));
            chk("ovf",         32'(ovf),         32'(m_ovf));
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    // Present an instruction until accepted; returns on the falling edge of READ.
    task automatic issue(input logic [31:0] ins);
        int n;
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready", 32'(instr_ready), 32'h1);
        tick();
        instr_valid = 1'b0;
        instr       = $urandom;
    endtask

    logic        we_seen;
    logic [31:0] w_addr, w_data;
    task automatic wait_done(output int n);
        n = 0;
        we_seen = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        do begin
            tick();
            n++;
            if (rf_we) begin
                we_seen = 1'b1;
                w_addr  = 32'(rf_addr);
                w_data  = rf_wdata;
            end
        end while (done !== 1'b1 && n < 12);
        chk("done_seen", 32'(done), 32'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_phase != 0 && n < 12) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, t0, t1, t2;
        logic [31:0] r;
        logic        w, e, o;
        logic [5:0]  op;
        logic [15:0] imm;
        int          k;

        reset       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(instr_ready), 32'h0);
        chk("rst_result", result, 32'h0);
        reset = 1'b1;
        tick();
        chk("ready_after_release", 32'(instr_ready), 32'h1);

        // Pin the model against hand-computed values.
        ref_exec(32'h20220001, 32'd212, r, w, e, o);
        chk("model_addi", r, 32'd213);
        ref_exec(32'h2C22FFFF, 32'd0, r, w, e, o);
        chk("model_sltiu", r, 32'd1);
        ref_exec(32'h20220001, 32'h7FFFFFFF, r, w, e, o);
        chk("model_addi_ovf", 32'(o), 32'h1);

        // addi r2,r1,1 with r1=212
        poke(5'd1, 32'd212);
        issue(32'h20220001);
        wait_done(lat);
        chk("addi_latency", lat, 3);
        chk("addi_waddr", w_addr, 32'd2);
        chk("addi_wdata", w_data, 32'd213);
        chk("addi_result", result, 32'd213);
        chk("addi_wrote", 32'(wrote), 32'h1);

        // Back-to-back andi / ori / lui
        issue(32'h30220001);
        t0 = cyc;
        issue(32'h34220001);
        t1 = cyc;
        issue(32'h3C031234);
        t2 = cyc;
        chk("b2b_spacing1", t1 - t0, 4);
        chk("b2b_spacing2", t2 - t1, 4);
        chk("ori_mem", rf_mem[2], 32'd213);
        wait_done(lat);
        chk("lui_result", result, 32'h12340000);
        chk("lui_mem", rf_mem[3], 32'h12340000);

        // addi overflow vs addiu
        poke(5'd1, 32'h7FFFFFFF);
        poke(5'd2, 32'hDEADBEEF);
        issue(32'h20220001);
        wait_done(lat);
        chk("ovf_flag", 32'(ovf), 32'h1);
        chk("ovf_result", result, 32'h80000000);
        chk("ovf_no_we", 32'(we_seen), 32'h0);
        chk("ovf_wrote", 32'(wrote), 32'h0);
        chk("ovf_mem", rf_mem[2], 32'hDEADBEEF);
        issue(32'h24220001);
        wait_done(lat);
        chk("addiu_ovf", 32'(ovf), 32'h0);
        chk("addiu_mem", rf_mem[2], 32'h80000000);

        // slti vs sltiu with imm=-1
        poke(5'd1, 32'h0);
        issue(32'h2822FFFF);
        wait_done(lat);
        chk("slti_result", result, 32'h0);
        issue(32'h2C22FFFF);
        wait_done(lat);
        chk("sltiu_result", result, 32'h1);

        // Illegal opcode and write to r0
        issue(32'h00220001);
        wait_done(lat);
        chk("illegal_err", 32'(err), 32'h1);
        chk("illegal_wrote", 32'(wrote), 32'h0);
        chk("illegal_no_we", 32'(we_seen), 32'h0);
        issue(32'h20200001);
        wait_done(lat);
        chk("r0_wrote", 32'(wrote), 32'h0);
        chk("r0_no_we", 32'(we_seen), 32'h0);

        // Reset during EXEC
        poke(5'd2, 32'h55);
        issue(32'h20220001);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_exec_ready", 32'(instr_ready), 32'h0);
        chk("rst_exec_we", 32'(rf_we), 32'h0);
        chk("rst_exec_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_exec_ready_rel", 32'(instr_ready), 32'h1);
        tick();
        chk("rst_exec_mem", rf_mem[2], 32'h55);

        // Randomized back-to-back traffic with occasional resets and pokes
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                poke(5'($urandom_range(1, 31)), pick_val());
            end
            k   = $urandom_range(0, 9);
            op  = (k < 8) ? 6'(8 + k) : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 5))
                0: imm = 16'h0000;
                1: imm = 16'hFFFF;
                2: imm = 16'h7FFF;
                3: imm = 16'h8000;
                4: imm = 16'h0001;
                default: imm = 16'($urandom);
            endcase
            issue({op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm});
            if ($urandom_range(0, 11) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
        end
        wait_idle();
        tick();
        tick();
        for (int i = 0; i < 32; i++) chk("final_reg", rf_mem[i], golden[i]);
        chk("r0_zero", rf_mem[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iformat_exec.md
# iformat_exec

Multi-cycle execute/write-back sequencer for I-format instructions (addi, addiu, slti, sltiu, andi, ori, xori, lui). It sits directly upstream of the single-port register file. It accepts one decoded 32-bit instruction word at a time, reads `rs` through the register-file port, applies the 16-bit immediate in the ALU, and writes the result back to `rt`. One instruction completes every 4 cycles; completion status goes to the issuing stage.

## Interface
Parameters:
- `DATA_W`, 32, register/data width
- `REG_AW`, 5, register-file address width

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`
- `instr`  in  32  instruction word; fields: opcode [31:26], rs [25:21], rt [20:16], imm [15:0]
- `instr_valid`  in  1  `instr` is valid this cycle
- `instr_ready`  out  1  block is able to accept an instruction (IDLE only)
- `rf_addr`  out  REG_AW  register-file address
- `rf_we`  out  1  register-file write enable
- `rf_wdata`  out  DATA_W  register-file write data
- `rf_rdata`  in  DATA_W  register-file read data; registered, valid the cycle after the address is presented with `rf_we`=0
- `done`  out  1  one-cycle pulse: instruction retired
- `result`  out  DATA_W  computed value; held from `done` until the next `done`
- `wrote`  out  1  qualifies `done`: a register write was performed
- `err`  out  1  qualifies `done`: illegal opcode
- `ovf`  out  1  qualifies `done`: addi signed overflow

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE→READ on `instr_valid && instr_ready`; the block latches `instr`.
  - READ→EXEC unconditionally. READ drives `rf_addr`=rs and `rf_we`=0.
  - EXEC→WRITE unconditionally. EXEC decodes the opcode, computes from `rf_rdata` and imm, and registers the result and flags.
  - WRITE→IDLE unconditionally. WRITE drives `rf_addr`=rt, `rf_wdata`=result, and `rf_we`=1 only if the write is permitted.
- Opcodes:
  - addi 001000: rs + sext(imm), wrap mod 2^32; signed overflow sets `ovf` and suppresses the write.
  - addiu 001001: same sum; never flags overflow.
  - slti 001010: signed rs < sext(imm) → 1, else 0.
  - sltiu 001011: unsigned rs < sext(imm) → 1, else 0.
  - andi 001100, ori 001101, xori 001110: use zext(imm).
  - lui 001111: imm << 16. The READ cycle is still spent, so timing is uniform.
  - Any other opcode: `err`=1, `result`=0, no write.
- Write is permitted iff the opcode is legal, `ovf`=0, and rt≠0. Register 0 is never written.
- `wrote`, `err`, and `ovf` update together with `done` and hold until the next `done`.

## Timing
- Accept on edge E0, with `instr_ready` falling after E0.
- READ occupies the cycle after E0; EXEC occupies the next cycle.
- WRITE occupies the cycle after EXEC; the register file commits on the edge ending WRITE (E3).
- After E3, `done`=1 for exactly one cycle and `instr_ready`=1 in the same cycle.
- A new instruction may be accepted in that same cycle (back-to-back issue). Throughput is 1 instruction per 4 cycles.
- `instr_valid` while not ready: ignored. The issuer must hold it until ready.
- Outputs outside READ/WRITE: `rf_we`=0, `rf_addr`=0, `rf_wdata`=0.
- Reset values (`reset`=0 at an edge): state IDLE, `instr_ready`=1 after the first clock edge with `reset`=1, everything else 0 (`rf_we`, `rf_addr`, `rf_wdata`, `done`, `result`, `wrote`, `err`, `ovf`).
- Reset mid-operation in any state:
  - The block returns to IDLE on that edge.
  - `rf_we` is 0 in the following cycle, so no partial write.
  - No `done` is issued for the aborted instruction.
- Reset asserted during WRITE: the write on that same edge still occurs, because the register file samples `rf_we` before reset takes effect. The bench must not count it as retired.

## Structure
- Shared package `iformat_pkg`:
  - opcode localparams (`OP_ADDI` … `OP_LUI`);
  - state enum/localparams `S_IDLE`, `S_READ`, `S_EXEC`, `S_WRITE`;
  - field bit positions.
- Sub-module `iformat_alu`, combinational:
  - inputs: opcode, rs value, imm;
  - outputs: value, `illegal`, `ovf`.
- Instantiated once in `iformat_exec`. FSM and output registers stay in the top.

## Test plan
- r1=212; issue addi r2,r1,1 (0x20220001) → WRITE cycle drives `rf_addr`=2, `rf_wdata`=213; `done` 4 cycles after accept with `wrote`=1.
- Back-to-back:
  - andi r2,r1,1 (0x30220001) → 0;
  - ori r2,r1,1 (0x34220001) → 213;
  - lui r3,0x1234 → 0x12340000;
  - `instr_ready` high exactly once per 4 cycles.
- r1=0x7FFFFFFF, addi r2,r1,1 → `ovf`=1, `rf_we` never 1, `result`=0x80000000. The same operands with addiu → write 0x80000000, `ovf`=0.
- slti r2,r1,0xFFFF with r1=0 → 0; sltiu with the same operands → 1.
- Opcode 000000 → `err`=1, `wrote`=0, no write. addi with rt=0 → `wrote`=0.
- `reset`=0 asserted in EXEC → next cycle IDLE, no `done`, `rf_we`=0; `instr_ready`=1 one cycle after release.
